// File: rtl/game_pkg.sv
// Shared game encodings: state codes (also used by the game FSM) and run phases.
package game_pkg;

   localparam logic [2:0] ST_RESET    = 3'b000;
   localparam logic [2:0] ST_NORM     = 3'b001;
   localparam logic [2:0] ST_COIN     = 3'b010;
   localparam logic [2:0] ST_OBST     = 3'b011;
   localparam logic [2:0] ST_GAMEOVER = 3'b100;

   localparam logic [1:0] PH_IDLE = 2'b00;
   localparam logic [1:0] PH_RUN  = 2'b01;
   localparam logic [1:0] PH_HALT = 2'b10;

endpackage

// File: rtl/evt_fifo.sv
// Small synchronous event FIFO with flush; a push during flush becomes the sole entry.
module evt_fifo #(
   parameter int DEPTH  = 4,
   parameter int CODE_W = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [CODE_W-1:0]          din_i,
   input  logic                       pop_i,
   output logic [CODE_W-1:0]          dout_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [CODE_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]    count_q;
   logic              do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= PTR_W'(push_i);
         rd_ptr_q <= '0;
         count_q  <= (PTR_W+1)'(push_i);
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      end
   end

   // Storage carries no reset; readers only look at it while the FIFO is non-empty.
   always_ff @(posedge clk) begin
      if (flush_i) begin
         if (push_i) mem_q[0] <= din_i;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

endmodule

// File: rtl/game_event_queue.sv
// Button edge detect, run-phase gating and event queue feeding the game FSM.
// Define GAME_EVT_DROP_CNT_EN to add the saturating 8-bit drop_cnt output.
module game_event_queue
   import game_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int CODE_W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   coin,
   input  logic                   obst,
   input  logic                   gameStart,
   input  logic                   game_over,
   input  logic                   evt_ready,
   output logic                   evt_valid,
   output logic [CODE_W-1:0]      evt_code,
   output logic [$clog2(DEPTH):0] q_count,
   output logic                   drop_pulse,
   output logic [1:0]             phase
`ifdef GAME_EVT_DROP_CNT_EN
   ,
   output logic [7:0]             drop_cnt
`endif
);

   logic              coin_prev_q, obst_prev_q, start_prev_q;
   logic              coin_rise, obst_rise, start_rise;
   logic [1:0]        phase_q, phase_d;
   logic              coin_pend_q, coin_pend_d;
   logic              drop_q, drop_d;
   logic              flush, push_req, pop;
   logic [CODE_W-1:0] push_code, fifo_dout;
   logic              fifo_full, fifo_empty;

   assign coin_rise  = coin & ~coin_prev_q;
   assign obst_rise  = obst & ~obst_prev_q;
   assign start_rise = gameStart & ~start_prev_q;

   assign evt_valid  = !fifo_empty;
   assign evt_code   = evt_valid ? fifo_dout : '0;
   assign pop        = evt_valid && evt_ready;
   assign phase      = phase_q;
   assign drop_pulse = drop_q;

   // Obst wins a simultaneous rise; the coin waits one cycle in coin_pend.
   always_comb begin
      phase_d     = phase_q;
      coin_pend_d = coin_pend_q;
      flush       = 1'b0;
      push_req    = 1'b0;
      push_code   = CODE_W'(ST_NORM);
      if (start_rise) begin
         flush       = 1'b1;
         push_req    = 1'b1;
         coin_pend_d = 1'b0;
         phase_d     = PH_RUN;
      end else if (phase_q == PH_RUN) begin
         if (game_over) begin
            phase_d     = PH_HALT;
            coin_pend_d = 1'b0;
         end else if (obst_rise) begin
            push_req    = 1'b1;
            push_code   = CODE_W'(ST_OBST);
            coin_pend_d = coin_pend_q | coin_rise;
         end else if (coin_pend_q) begin
            push_req    = 1'b1;
            push_code   = CODE_W'(ST_COIN);
            coin_pend_d = coin_rise;
         end else if (coin_rise) begin
            push_req    = 1'b1;
            push_code   = CODE_W'(ST_COIN);
         end
      end
   end

   assign drop_d = push_req && !flush && fifo_full && !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coin_prev_q  <= 1'b1;
         obst_prev_q  <= 1'b1;
         start_prev_q <= 1'b1;
         phase_q      <= PH_IDLE;
         coin_pend_q  <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         coin_prev_q  <= coin;
         obst_prev_q  <= obst;
         start_prev_q <= gameStart;
         phase_q      <= phase_d;
         coin_pend_q  <= coin_pend_d;
         drop_q       <= drop_d;
      end
   end

`ifdef GAME_EVT_DROP_CNT_EN
   logic [7:0] drop_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= '0;
      end else if (start_rise) begin
         drop_cnt_q <= '0;
      end else if (drop_q && drop_cnt_q != 8'hFF) begin
         drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   evt_fifo #(
      .DEPTH  (DEPTH),
      .CODE_W (CODE_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .push_i  (push_req),
      .din_i   (push_code),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (q_count)
   );

endmodule

// File: doc/game_event_queue.md
# game_event_queue

Sits between the three button debouncers and the `game` state machine. Converts debounced coin, obstacle and start levels into one-cycle rising-edge events and gates them by run phase. Queues accepted events in a small FIFO and presents them one at a time, over a valid/ready handshake, as 3-bit game state codes. This means the game FSM never misses a press that lands between its slow ticks.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CODE_W`, default 3: event code width; matches the game state encoding.

Ports:
- `clk`  in  1: system clock (100 MHz board clock; all logic on this clock).
- `rst`  in  1: asynchronous, active-low reset.
- `coin`  in  1: debounced coin button level.
- `obst`  in  1: debounced obstacle button level.
- `gameStart`  in  1: debounced start button level.
- `game_over`  in  1: level from the game FSM; high while in GAMEOVER.
- `evt_ready`  in  1: consumer accepts the head event this cycle.
- `evt_valid`  out  1: head event present.
- `evt_code`  out  CODE_W: head event code (NORM=001, COIN=010, OBST=011).
- `q_count`  out  $clog2(DEPTH)+1: entries currently held.
- `drop_pulse`  out  1: one-cycle strobe when an accepted event finds the FIFO full.
- `phase`  out  2: current phase (IDLE=00, RUN=01, HALT=10).

## Operation
- Edge detect: each input has a `prev` register. Rise = `in & ~prev`.
  - All `prev` registers reset to 1, so a level held high through reset produces no event until it falls and rises again.
- Phase FSM:
  - IDLE → RUN on start rise.
  - RUN → HALT when `game_over`=1.
  - HALT → RUN on start rise.
  - Reset → IDLE.
  - Coin and obst rises are discarded silently in IDLE and HALT (no `drop_pulse`).
- Start rise, in any phase: flushes FIFO and pending coin, then writes NORM as the sole entry. `q_count`=1 the next cycle.
- Coin rise (RUN): push COIN.
- Obst rise (RUN): push OBST.
- Coin and obst rise in the same cycle: OBST pushed that cycle; coin held in 1-bit `coin_pend`, pushed the following cycle.
  - A new obst rise in that following cycle is pushed instead, and `coin_pend` holds another cycle.
  - Start flush clears `coin_pend`.
  - Entering HALT clears `coin_pend`.
- Pop: `evt_valid && evt_ready`. Head advances; `q_count` decrements.
- Full and push, no pop: event dropped; `drop_pulse`=1 for one cycle; FIFO unchanged.
- Full and push with pop in the same cycle: push accepted; `q_count` stays DEPTH.
- Empty and push in the same cycle: no bypass. `evt_valid` rises the next cycle; `evt_ready` is ignored while `evt_valid`=0.
- Pointers wrap modulo DEPTH. `q_count` ranges 0..DEPTH.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_code`=000, `q_count`=0, `drop_pulse`=0, `phase`=IDLE.
  - Pointers 0, `coin_pend`=0.
- Latency: input first sampled high at edge N → `evt_valid`=1 after edge N (visible cycle N+1). Pending coin is visible one cycle later.
- Throughput: one pop per cycle. `evt_code` is stable while `evt_valid`=1 and `evt_ready`=0.
- Reset mid-operation: all state cleared asynchronously. Queued events are lost.

## Configuration
- `GAME_EVT_DROP_CNT_EN` defined: adds output `drop_cnt` (8 bits).
  - Increments on every `drop_pulse` and saturates at 255.
  - Cleared by reset and by start flush.
- Not defined: no `drop_cnt` port and no counter logic. `drop_pulse` is unchanged.

## Structure
- Shared package `game_pkg`:
  - Game state codes RESET=000, NORM=001, COIN=010, OBST=011, GAMEOVER=100 (also used by `game`).
  - Phase encoding IDLE/RUN/HALT.
- One sub-module, `evt_fifo`: synchronous FIFO with `flush`, `push`, `pop`, `full`, `empty` and count, parameterised by DEPTH and CODE_W.
- Edge detect, phase FSM and pending-coin logic live in the top module.

## Test plan
- Reset with `coin`=1 held, release reset, then start rise → after one cycle, `phase`=RUN, `evt_code`=001, `q_count`=1; no COIN event.
- In RUN, `evt_ready`=0, 5 coin rises → `q_count`=4, one `drop_pulse`; then drain → four COIN (010) codes in order.
- Coin and obst rise in the same cycle, `evt_ready`=1 → OBST (011) popped first, COIN (010) the next cycle.
- FIFO full with `evt_ready`=1 and an obst rise in the same cycle → `q_count` stays 4, no `drop_pulse`, OBST at tail.
- `game_over`=1, then coin and obst rises → no push, no `drop_pulse`, `phase`=HALT; start rise → `phase`=RUN, queue holds a single NORM.
- `GAME_EVT_DROP_CNT_EN` defined, 300 drops → `drop_cnt`=255; start rise → `drop_cnt`=0.
